// File: rtl/out_change_fifo.sv
// Samples a bus on enabled cycles and queues each changed value in a small FWFT FIFO.
// Optional saturating dropped-change counter when OUT_CHANGE_DROP_CNT_EN is defined.
module out_change_fifo #(
   parameter int DATA_W = 6,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              smp_en,
   input  logic [DATA_W-1:0] in_data,
   input  logic              ovf_clr,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic [CNT_W-1:0]  change_cnt,
   output logic              overflow,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FILL_W = PTR_W + 1;
   localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(DEPTH);
   localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};

   logic [DATA_W-1:0] prev_r;
   logic              primed_r;
   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [FILL_W-1:0] fill_r;

   logic              change_s;
   logic              pop_s;
   logic              push_s;
   logic              drop_s;
   logic [PTR_W-1:0]  rd_ptr_nxt_s;
   logic [FILL_W-1:0] fill_after_pop_s;
   logic [FILL_W-1:0] fill_nxt_s;
   logic [DATA_W-1:0] head_nxt_s;

   // Change detection, push/pop decisions and the next FIFO head value.
   always_comb begin
      change_s         = 1'b0;
      pop_s            = rd_valid & rd_ready;
      push_s           = 1'b0;
      drop_s           = 1'b0;
      rd_ptr_nxt_s     = rd_ptr_r;
      fill_after_pop_s = fill_r;
      fill_nxt_s       = fill_r;
      head_nxt_s       = {DATA_W{1'b0}};

      if (smp_en) begin
         change_s = !primed_r || (in_data != prev_r);
      end else begin
         change_s = 1'b0;
      end

      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push_s = change_s && (!full || pop_s);
      drop_s = change_s && full && !pop_s;

      if (pop_s) begin
         rd_ptr_nxt_s     = rd_ptr_r + PTR_W'(1);
         fill_after_pop_s = fill_r - FILL_W'(1);
      end else begin
         rd_ptr_nxt_s     = rd_ptr_r;
         fill_after_pop_s = fill_r;
      end

      if (push_s) begin
         fill_nxt_s = fill_after_pop_s + FILL_W'(1);
      end else begin
         fill_nxt_s = fill_after_pop_s;
      end

      // The head is registered, so a write into an otherwise-empty FIFO becomes the head directly.
      if (fill_nxt_s == FILL_ZERO) begin
         head_nxt_s = {DATA_W{1'b0}};
      end else if (push_s && (fill_after_pop_s == FILL_ZERO)) begin
         head_nxt_s = in_data;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Sample history, FIFO storage/pointers, registered status outputs and change counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r     <= {DATA_W{1'b0}};
         primed_r   <= 1'b0;
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         fill_r     <= FILL_ZERO;
         rd_valid   <= 1'b0;
         rd_data    <= {DATA_W{1'b0}};
         full       <= 1'b0;
         change_cnt <= {CNT_W{1'b0}};
         overflow   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         if (smp_en) begin
            prev_r   <= in_data;
            primed_r <= 1'b1;
         end
         if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         rd_ptr_r <= rd_ptr_nxt_s;
         fill_r   <= fill_nxt_s;
         rd_valid <= (fill_nxt_s != FILL_ZERO);
         full     <= (fill_nxt_s == DEPTH_F);
         rd_data  <= head_nxt_s;
         if (change_s) begin
            change_cnt <= change_cnt + CNT_W'(1);
         end
         if (drop_s) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef OUT_CHANGE_DROP_CNT_EN
   logic [CNT_W-1:0] drop_cnt_r;

   // Saturating count of changes lost to a full FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_r <= {CNT_W{1'b0}};
      end else if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
         drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
   end

   assign drop_cnt = drop_cnt_r;
`else
   assign drop_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_out_change_fifo.sv
// Scoreboard bench for out_change_fifo: a queue-based reference model predicts status and
// read data; a separate monitor checks every read handshake against the expected-read queue.
module tb_out_change_fifo;

   localparam int DATA_W = 6;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 8;

   logic              clk;
   logic              rst;
   logic              smp_en;
   logic [DATA_W-1:0] in_data;
   logic              ovf_clr;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              full;
   logic [CNT_W-1:0]  change_cnt;
   logic              overflow;
   logic [CNT_W-1:0]  drop_cnt;

   out_change_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .smp_en(smp_en), .in_data(in_data), .ovf_clr(ovf_clr),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .full(full),
      .change_cnt(change_cnt), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // reference model state
   logic [DATA_W-1:0] m_q[$];
   logic [DATA_W-1:0] rd_exp_q[$];
   logic [DATA_W-1:0] m_prev;
   bit                m_primed;
   int                m_cnt;
   int                m_drop;
   bit                m_ovf;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic check_state();
      logic [DATA_W-1:0] head;
      head = (m_q.size() != 0) ? m_q[0] : 6'h00;
      chk("rd_valid",   32'(rd_valid),   32'(m_q.size() != 0));
      chk("rd_data",    32'(rd_data),    32'(head));
      chk("full",       32'(full),       32'(m_q.size() == DEPTH));
      chk("change_cnt", 32'(change_cnt), 32'(m_cnt));
      chk("overflow",   32'(overflow),   32'(m_ovf));
      chk("drop_cnt",   32'(drop_cnt),   32'(m_drop));
   endtask

   task automatic model_edge(input bit r, input bit se, input logic [DATA_W-1:0] d,
                             input bit rr, input bit oc);
      bit change;
      bit dropped;
      if (r) begin
         m_q.delete();
         m_prev   = 6'h00;
         m_primed = 1'b0;
         m_cnt    = 0;
         m_drop   = 0;
         m_ovf    = 1'b0;
      end else begin
         if (rr && m_q.size() != 0) rd_exp_q.push_back(m_q.pop_front());
         change  = se && (!m_primed || d != m_prev);
         dropped = 1'b0;
         if (se) begin
            m_prev   = d;
            m_primed = 1'b1;
         end
         if (change) begin
            m_cnt = (m_cnt + 1) % 256;
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else dropped = 1'b1;
         end
         if (dropped) begin
            m_ovf = 1'b1;
`ifdef OUT_CHANGE_DROP_CNT_EN
            if (m_drop < 255) m_drop = m_drop + 1;
`endif
         end else if (oc) begin
            m_ovf = 1'b0;
         end
      end
   endtask

   // Called 1 time unit after a rising edge: check, drive, predict, advance one cycle.
   task automatic step(input bit r, input bit se, input logic [DATA_W-1:0] d,
                       input bit rr, input bit oc);
      if (chk_en) check_state();
      rst      = r;
      smp_en   = se;
      in_data  = d;
      rd_ready = r ? 1'b0 : rr;
      ovf_clr  = oc;
      model_edge(r, se, d, r ? 1'b0 : rr, oc);
      @(posedge clk);
      #1;
      chk_en = 1'b1;
   endtask

   // Monitor: every accepted read must match the next expected value, and none may be missed.
   initial begin
      logic [DATA_W-1:0] e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (rd_exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL pop_unexpected: got data %0h expected no handshake", rd_data);
            end else begin
               e = rd_exp_q.pop_front();
               chk("pop_data", 32'(rd_data), 32'(e));
            end
         end else if (rd_exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_missing: got no handshake expected data %0h", rd_exp_q[0]);
            rd_exp_q.delete();
         end
      end
   end

   initial begin
      logic [DATA_W-1:0] d;
      rst = 1'b1; smp_en = 1'b0; in_data = 6'h00; rd_ready = 1'b0; ovf_clr = 1'b0;

      // reset state
      step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
      step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);

      // one value held three cycles
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'h05, 1'b0, 1'b0);
      step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      chk("hold_cnt", 32'(change_cnt), 32'd1);

      // fill to overflow
      step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         d = 6'(i);
         step(1'b0, 1'b1, d, 1'b0, 1'b0);
      end
      step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_ovf",  32'(overflow), 32'd1);
      chk("fill_cnt",  32'(change_cnt), 32'd5);

      // push while full with simultaneous pop
      step(1'b0, 1'b1, 6'h06, 1'b1, 1'b0);
      step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      chk("pp_full", 32'(full), 32'd1);
      chk("pp_head", 32'(rd_data), 32'h02);

      // drain, then clear overflow
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      chk("drain_data", 32'(rd_data), 32'h00);
      step(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
      step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      chk("ovf_clr", 32'(overflow), 32'd0);

      // reset with entries queued, then a value equal to the old one
      step(1'b0, 1'b1, 6'h0a, 1'b0, 1'b0);
      step(1'b0, 1'b1, 6'h0b, 1'b0, 1'b0);
      step(1'b0, 1'b1, 6'h05, 1'b0, 1'b0);
      step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
      step(1'b0, 1'b1, 6'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      chk("rst_first", 32'(change_cnt), 32'd1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) d = 6'($urandom_range(0, 63));
         else d = 6'($urandom_range(0, 3));
         step(($urandom_range(0, 999) == 0),
              ($urandom_range(0, 3) != 0),
              d,
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 15) == 0));
      end

      step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      check_state();
      chk("exp_q_empty", 32'(rd_exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
